// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the IF stage: pipeline words, halt/drain states and PC helpers.
// Decode, hazard and the CPU bench import the same package.
package fetch_stage_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } fetch_state_e;

    localparam word_t RESET_PC_DEF     = 32'h0000_0000;
    localparam word_t HALT_WORD_DEF    = 32'hFC00_0000;
    localparam word_t NOP_WORD_DEF     = 32'h0000_0000;
    localparam int    DRAIN_CYCLES_DEF = 4;

    function automatic word_t next_seq_pc(input word_t pc);
        return pc + 32'd4;
    endfunction

    // Redirect targets are word addresses; any stray low bits are dropped.
    function automatic word_t word_align(input word_t addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Bus between the fetch stage and its surroundings: instruction memory,
// hazard/branch units, the IF/ID register consumer and the halt flag.
interface fetch_stage_if;
    import fetch_stage_pkg::*;

    word_t instructionAddress;
    word_t instruction;
    logic  stall;
    logic  branch_taken;
    word_t branch_target;
    word_t ifid_instr;
    word_t ifid_pc4;
    logic  ifid_valid;
    logic  halted;

    modport master (
        output instructionAddress,
        input  instruction,
        input  stall,
        input  branch_taken,
        input  branch_target,
        output ifid_instr,
        output ifid_pc4,
        output ifid_valid,
        output halted
    );

    modport slave (
        input  instructionAddress,
        output instruction,
        output stall,
        output branch_taken,
        output branch_target,
        input  ifid_instr,
        input  ifid_pc4,
        input  ifid_valid,
        input  halted
    );

endinterface

// File: rtl/fetch_stage_halt_drain_fsm.sv
// Halt/drain control for the fetch stage: decides each cycle whether the PC holds and
// whether IF/ID takes a bubble, and counts the drain cycles after a HALT fetch.
module halt_drain_fsm
    import fetch_stage_pkg::*;
#(
    parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic i_halt_seen,
    input  logic i_redirect,
    input  logic i_stall,
    output logic o_pc_hold,
    output logic o_bubble,
    output logic o_halted
);

    localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(DRAIN_CYCLES - 1);

    fetch_state_e     r_state;
    fetch_state_e     w_stateNext;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_countNext;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_RUN;
            r_count <= '0;
        end else begin
            r_state <= w_stateNext;
            r_count <= w_countNext;
        end
    end

    // A redirect is the only event that lets the PC move outside plain sequential fetch;
    // during a drain it means the HALT was on a wrong path, so fetching resumes.
    always_comb begin
        w_stateNext = r_state;
        w_countNext = r_count;
        o_pc_hold   = 1'b1;
        o_bubble    = 1'b1;
        unique case (r_state)
            ST_RUN: begin
                if (i_redirect) begin
                    o_pc_hold = 1'b0;
                end else if (i_stall) begin
                    o_bubble = 1'b0;
                end else if (i_halt_seen) begin
                    w_stateNext = ST_DRAIN;
                    w_countNext = '0;
                end else begin
                    o_pc_hold = 1'b0;
                    o_bubble  = 1'b0;
                end
            end
            ST_DRAIN: begin
                if (i_redirect) begin
                    o_pc_hold   = 1'b0;
                    w_stateNext = ST_RUN;
                    w_countNext = '0;
                end else if (r_count == LAST_COUNT) begin
                    w_stateNext = ST_HALTED;
                end else begin
                    w_countNext = r_count + CNT_W'(1);
                end
            end
            ST_HALTED: begin
                w_stateNext = ST_HALTED;
            end
            default: begin
                w_stateNext = ST_RUN;
                w_countNext = '0;
            end
        endcase
    end

    assign o_halted = (r_state == ST_HALTED);

endmodule

// File: rtl/fetch_stage.sv
// IF stage of the 5-stage MIPS pipeline with the IF/ID register. Owns the PC, applies
// stall/redirect requests and hands HALT detection to halt_drain_fsm.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter word_t RESET_PC     = RESET_PC_DEF,
    parameter word_t HALT_WORD    = HALT_WORD_DEF,
    parameter word_t NOP_WORD     = NOP_WORD_DEF,
    parameter int    DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
    input  logic          clk,
    input  logic          reset,
    fetch_stage_if.master bus
);

    word_t r_pc;
    word_t r_ifidInstr;
    word_t r_ifidPc4;
    logic  r_ifidValid;

    word_t w_pcPlus4;
    logic  w_haltSeen;
    logic  w_pcHold;
    logic  w_bubble;
    logic  w_halted;

    assign w_pcPlus4  = next_seq_pc(r_pc);
    assign w_haltSeen = (bus.instruction == HALT_WORD);

    halt_drain_fsm #(
        .DRAIN_CYCLES (DRAIN_CYCLES)
    ) u_haltDrain (
        .clk         (clk),
        .reset       (reset),
        .i_halt_seen (w_haltSeen),
        .i_redirect  (bus.branch_taken),
        .i_stall     (bus.stall),
        .o_pc_hold   (w_pcHold),
        .o_bubble    (w_bubble),
        .o_halted    (w_halted)
    );

    // When the FSM releases the PC it either follows a redirect or steps sequentially.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc <= RESET_PC;
        end else if (!w_pcHold) begin
            r_pc <= bus.branch_taken ? word_align(bus.branch_target) : w_pcPlus4;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ifidInstr <= NOP_WORD;
            r_ifidPc4   <= '0;
            r_ifidValid <= 1'b0;
        end else if (w_bubble) begin
            r_ifidInstr <= NOP_WORD;
            r_ifidPc4   <= '0;
            r_ifidValid <= 1'b0;
        end else if (!bus.stall) begin
            r_ifidInstr <= bus.instruction;
            r_ifidPc4   <= w_pcPlus4;
            r_ifidValid <= 1'b1;
        end
    end

    assign bus.instructionAddress = r_pc;
    assign bus.ifid_instr         = r_ifidInstr;
    assign bus.ifid_pc4           = r_ifidPc4;
    assign bus.ifid_valid         = r_ifidValid;
    assign bus.halted             = w_halted;

endmodule
